// File: rtl/demux1x4_stripe_pkg.sv
// Shared constants and phase encoding for the 1:4 byte de-striper.
package demux1x4_stripe_pkg;

    localparam int LANES          = 4;
    localparam int PHASE_W        = 2;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [PHASE_W-1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

endpackage

// File: rtl/demux_phase_ctr.sv
// Free-running frame phase counter; align from a non-zero phase restarts the frame.
module demux_phase_ctr
    import demux1x4_stripe_pkg::*;
(
    input  logic   clk4f,
    input  logic   reset,
    input  logic   align,
    output phase_t phase,
    output logic   load_en
);

    phase_t phase_reg;
    phase_t phase_next;

    always_ff @(posedge clk4f) begin
        if (reset) begin
            phase_reg <= PH0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        phase_next = PH0;
        load_en    = 1'b0;
        case (phase_reg)
            PH0: phase_next = PH1;
            PH1: phase_next = PH2;
            PH2: phase_next = PH3;
            PH3: begin
                phase_next = PH0;
                load_en    = 1'b1;
            end
            default: phase_next = PH0;
        endcase
        // At phase 0 a realign is already satisfied, so it only acts mid-frame.
        if (align && (phase_reg != PH0)) begin
            phase_next = PH0;
            load_en    = 1'b0;
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/demux1x4_stripe.sv
// Collects four serial bytes per frame and presents them as four registered lanes.
module demux1x4_stripe
    import demux1x4_stripe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic              clk4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              valid_in,
    input  logic              align,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [LANES-1:0]  valid,
    output logic              frame_stb
);

    phase_t               phase;
    logic [PHASE_W-1:0]   phase_bits;
    logic                 load_en;
    logic                 abort;
    logic [DATA_W-1:0]    frame_data [LANES];
    logic [LANES-1:0]     frame_valid;
    logic [DATA_W-1:0]    lane_out [LANES];
    logic                 frame_stb_reg;

    demux_phase_ctr u_phase_ctr (
        .clk4f   (clk4f),
        .reset   (reset),
        .align   (align),
        .phase   (phase),
        .load_en (load_en)
    );

    assign phase_bits = phase;
    assign abort      = align && (phase != PH0);

    genvar gi;
    generate
        // Lanes 0..2 are buffered; the last lane comes straight from the input on the load edge.
        for (gi = 0; gi < LANES - 1; gi++) begin : g_buf
            logic [DATA_W-1:0] lane_buf_reg;
            logic              vbuf_reg;

            always_ff @(posedge clk4f) begin
                if (reset || abort) begin
                    lane_buf_reg <= '0;
                    vbuf_reg     <= 1'b0;
                end else if (phase_bits == PHASE_W'(gi)) begin
                    lane_buf_reg <= in;
                    vbuf_reg     <= valid_in;
                end
            end

            assign frame_data[gi]  = lane_buf_reg;
            assign frame_valid[gi] = vbuf_reg;
        end

        for (gi = 0; gi < LANES; gi++) begin : g_out
            logic [DATA_W-1:0] out_reg;
            logic              vld_reg;

            always_ff @(posedge clk4f) begin
                if (reset) begin
                    out_reg <= '0;
                    vld_reg <= 1'b0;
                end else if (load_en) begin
                    vld_reg <= frame_valid[gi];
                    out_reg <= frame_valid[gi] ? frame_data[gi] : '0;
                end
            end

            assign lane_out[gi] = out_reg;
            assign valid[gi]    = vld_reg;
        end
    endgenerate

    assign frame_data[LANES-1]  = in;
    assign frame_valid[LANES-1] = valid_in;

    always_ff @(posedge clk4f) begin
        if (reset) begin
            frame_stb_reg <= 1'b0;
        end else begin
            frame_stb_reg <= load_en;
        end
    end

    assign frame_stb = frame_stb_reg;
    assign out0      = lane_out[0];
    assign out1      = lane_out[1];
    assign out2      = lane_out[2];
    assign out3      = lane_out[3];

endmodule

// File: tb/tb_demux1x4_stripe.sv
// Directed and randomized checks of the 1:4 de-striper against a frame-queue reference model.
module tb_demux1x4_stripe;

    logic       clk;
    logic       reset_s;
    logic [7:0] in_s;
    logic       valid_in_s;
    logic       align_s;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] valid;
    logic       frame_stb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stb_seen = 0;
    int last_stb_cyc = 0;

    // Reference model: bytes of the frame in progress, and the expected registered outputs.
    logic [7:0] q_d [$];
    logic       q_v [$];
    logic [7:0] exp_out [4];
    logic [3:0] exp_valid;
    logic       exp_stb;

    demux1x4_stripe #(.DATA_W(8)) dut (
        .clk4f     (clk),
        .reset     (reset_s),
        .in        (in_s),
        .valid_in  (valid_in_s),
        .align     (align_s),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .valid     (valid),
        .frame_stb (frame_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic [7:0] d, input logic v, input logic al, input logic rst);
        exp_stb = 1'b0;
        if (rst) begin
            q_d.delete();
            q_v.delete();
            for (int k = 0; k < 4; k++) exp_out[k] = 8'h00;
            exp_valid = 4'h0;
        end else if (al && q_d.size() > 0) begin
            q_d.delete();
            q_v.delete();
        end else begin
            q_d.push_back(d);
            q_v.push_back(v);
            if (q_d.size() == 4) begin
                for (int k = 0; k < 4; k++) begin
                    exp_out[k]   = q_v[k] ? q_d[k] : 8'h00;
                    exp_valid[k] = q_v[k];
                end
                exp_stb = 1'b1;
                q_d.delete();
                q_v.delete();
            end
        end
    endtask

    task automatic cycle(input logic [7:0] d, input logic v, input logic al, input logic rst);
        in_s       = d;
        valid_in_s = v;
        align_s    = al;
        reset_s    = rst;
        model_step(d, v, al, rst);
        @(posedge clk);
        #1;
        cyc++;
        if (frame_stb === 1'b1) begin
            stb_seen++;
            last_stb_cyc = cyc;
        end
        check("out0", {24'h0, out0}, {24'h0, exp_out[0]});
        check("out1", {24'h0, out1}, {24'h0, exp_out[1]});
        check("out2", {24'h0, out2}, {24'h0, exp_out[2]});
        check("out3", {24'h0, out3}, {24'h0, exp_out[3]});
        check("valid", {28'h0, valid}, {28'h0, exp_valid});
        check("frame_stb", {31'h0, frame_stb}, {31'h0, exp_stb});
        $display("cyc=%0d rst=%0b al=%0b in=%02h vin=%0b -> out=%02h %02h %02h %02h valid=%04b stb=%0b",
                 cyc, rst, al, d, v, out0, out1, out2, out3, valid, frame_stb);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [3:0] v);
        cycle(b0, v[0], 1'b0, 1'b0);
        cycle(b1, v[1], 1'b0, 1'b0);
        cycle(b2, v[2], 1'b0, 1'b0);
        cycle(b3, v[3], 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] ev);
        check({tag, "_out0"}, {24'h0, out0}, {24'h0, e0});
        check({tag, "_out1"}, {24'h0, out1}, {24'h0, e1});
        check({tag, "_out2"}, {24'h0, out2}, {24'h0, e2});
        check({tag, "_out3"}, {24'h0, out3}, {24'h0, e3});
        check({tag, "_valid"}, {28'h0, valid}, {28'h0, ev});
    endtask

    initial begin
        int s, c0, c1;
        logic [7:0] lanes [4];
        logic [3:0] lv;
        logic [7:0] exp_lane [4];

        for (int k = 0; k < 4; k++) exp_out[k] = 8'h00;
        exp_valid  = 4'h0;
        exp_stb    = 1'b0;
        reset_s    = 1'b1;
        in_s       = 8'h00;
        valid_in_s = 1'b0;
        align_s    = 1'b0;

        // Reset for two cycles
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        check_outs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        check("reset_stb", {31'h0, frame_stb}, 32'h0);

        // Basic frame, latency of lane 0 is four cycles
        s  = stb_seen;
        c0 = cyc;
        frame(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        check_outs("basic", 8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        check("basic_stbcnt", stb_seen - s, 1);
        check("basic_latency", last_stb_cyc - c0, 4);

        // Mixed valids mask lane data to zero
        frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0101);
        check_outs("mixed", 8'hAA, 8'h00, 8'hCC, 8'h00, 4'b0101);

        // Back-to-back frames
        s = stb_seen;
        frame(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
        check_outs("b2b_first", 8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
        c1 = last_stb_cyc;
        frame(8'h05, 8'h06, 8'h07, 8'h08, 4'b1111);
        check_outs("b2b_second", 8'h05, 8'h06, 8'h07, 8'h08, 4'b1111);
        check("b2b_gap", last_stb_cyc - c1, 4);
        check("b2b_stbcnt", stb_seen - s, 2);

        // Align at phase 2 aborts the frame in progress
        s = stb_seen;
        cycle(8'h55, 1'b1, 1'b0, 1'b0);
        cycle(8'h66, 1'b1, 1'b0, 1'b0);
        cycle(8'h77, 1'b1, 1'b1, 1'b0);
        check_outs("align2_hold", 8'h05, 8'h06, 8'h07, 8'h08, 4'b1111);
        check("align2_nostb", stb_seen - s, 0);
        frame(8'h99, 8'h9A, 8'h9B, 8'h9C, 4'b1111);
        check_outs("align2_next", 8'h99, 8'h9A, 8'h9B, 8'h9C, 4'b1111);

        // Reset at phase 2 discards the partial frame
        frame(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        cycle(8'hE1, 1'b1, 1'b0, 1'b0);
        cycle(8'hE2, 1'b1, 1'b0, 1'b0);
        s = stb_seen;
        cycle(8'hE3, 1'b1, 1'b0, 1'b1);
        check_outs("midreset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4'b1111);
        check_outs("midreset_next", 8'hA1, 8'hA2, 8'hA3, 8'hA4, 4'b1111);
        check("midreset_stbcnt", stb_seen - s, 1);

        // Align at phase 0 is a no-op
        cycle(8'hB0, 1'b1, 1'b1, 1'b0);
        cycle(8'hB1, 1'b1, 1'b0, 1'b0);
        cycle(8'hB2, 1'b1, 1'b0, 1'b0);
        cycle(8'hB3, 1'b1, 1'b0, 1'b0);
        check_outs("align0", 8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1111);

        // Align at phase 3 wins over the load
        s = stb_seen;
        cycle(8'hC0, 1'b1, 1'b0, 1'b0);
        cycle(8'hC1, 1'b1, 1'b0, 1'b0);
        cycle(8'hC2, 1'b1, 1'b0, 1'b0);
        cycle(8'hC3, 1'b1, 1'b1, 1'b0);
        check_outs("align3", 8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1111);
        check("align3_nostb", stb_seen - s, 0);

        // Reset and align together: reset wins
        cycle(8'hD0, 1'b1, 1'b0, 1'b0);
        cycle(8'hD1, 1'b1, 1'b1, 1'b1);
        check_outs("rst_align", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // All-invalid frame still strobes
        s = stb_seen;
        frame(8'h12, 8'h34, 8'h56, 8'h78, 4'b0000);
        check_outs("allinv", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        check("allinv_stbcnt", stb_seen - s, 1);

        // Random round trip through a 4:1 mux, with occasional aborted partial frames
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(7) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) cycle(8'($urandom), 1'($urandom), 1'b0, 1'b0);
                cycle(8'($urandom), 1'($urandom), 1'b1, 1'b0);
            end
            for (int k = 0; k < 4; k++) lanes[k] = 8'($urandom);
            lv = 4'($urandom);
            for (int k = 0; k < 4; k++) exp_lane[k] = lv[k] ? lanes[k] : 8'h00;
            frame(lanes[0], lanes[1], lanes[2], lanes[3], lv);
            check_outs("rand", exp_lane[0], exp_lane[1], exp_lane[2], exp_lane[3], lv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
